// File: rtl/pl_branch_predictor_bht.sv
// Bimodal (or gshare when PL_BP_GSHARE_EN is defined) branch predictor: saturating-counter BHT
// plus direct-mapped BTB, combinational IF lookup, MEM-stage update, resolution statistics.
module pl_branch_predictor_bht #(
    parameter int BHT_IDX_W = 6,
    parameter int CTR_W     = 2,
    parameter int BTB_IDX_W = 4,
    parameter int GHR_W     = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [31:0]          fetch_pc,
    input  logic                 fetch_is_branch,
    output logic                 pred_taken,
    output logic                 pred_hit,
    output logic [31:0]          pred_target,
    output logic [BHT_IDX_W-1:0] pred_idx,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_pc,
    input  logic [BHT_IDX_W-1:0] upd_idx,
    input  logic                 upd_taken,
    input  logic [31:0]          upd_target,
    input  logic                 upd_mispredict,
    output logic [31:0]          stat_branches,
    output logic [31:0]          stat_mispred
);
    localparam int BHT_N = 1 << BHT_IDX_W;
    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam int TAG_W = 30 - BTB_IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;

    logic [CTR_W-1:0]  ctr_reg        [BHT_N];
    logic [CTR_W-1:0]  ctr_next       [BHT_N];
    logic              btb_valid_reg  [BTB_N];
    logic [TAG_W-1:0]  btb_tag_reg    [BTB_N];
    logic [31:0]       btb_target_reg [BTB_N];
    logic [31:0]       stat_branches_reg;
    logic [31:0]       stat_mispred_reg;

    logic                 upd_en;
    logic [BHT_IDX_W-1:0] fetch_bht_idx;
    logic [BTB_IDX_W-1:0] fetch_btb_idx;
    logic [TAG_W-1:0]     fetch_tag;
    logic [BTB_IDX_W-1:0] upd_btb_idx;
    logic [TAG_W-1:0]     upd_tag;
    logic                 unused_upd_pc_lsbs;

    assign upd_en             = upd_valid & enable;
    assign fetch_bht_idx      = fetch_pc[BHT_IDX_W+1:2];
    assign fetch_btb_idx      = fetch_pc[BTB_IDX_W+1:2];
    assign fetch_tag          = fetch_pc[31:BTB_IDX_W+2];
    assign upd_btb_idx        = upd_pc[BTB_IDX_W+1:2];
    assign upd_tag            = upd_pc[31:BTB_IDX_W+2];
    assign unused_upd_pc_lsbs = ^upd_pc[1:0];

`ifdef PL_BP_GSHARE_EN
    // History is shifted only at resolution, so the lookup this cycle uses the old GHR.
    logic [GHR_W-1:0] ghr_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr_reg <= '0;
        end else if (upd_en) begin
            ghr_reg <= {ghr_reg[GHR_W-2:0], upd_taken};
        end
    end

    assign pred_idx = fetch_bht_idx ^ BHT_IDX_W'(ghr_reg);
`else
    assign pred_idx = fetch_bht_idx;
`endif

    assign pred_hit    = btb_valid_reg[fetch_btb_idx] && (btb_tag_reg[fetch_btb_idx] == fetch_tag);
    assign pred_taken  = fetch_is_branch & ctr_reg[pred_idx][CTR_W-1] & pred_hit;
    assign pred_target = pred_taken ? btb_target_reg[fetch_btb_idx] : fetch_pc + 32'd4;

    // Saturating next value per counter; only the entry selected by upd_idx moves.
    genvar gi;
    generate
        for (gi = 0; gi < BHT_N; gi++) begin : g_ctr
            logic sel;
            assign sel = upd_en && (upd_idx == BHT_IDX_W'(gi));
            assign ctr_next[gi] =
                (sel &&  upd_taken && ctr_reg[gi] != CTR_MAX) ? ctr_reg[gi] + 1'b1 :
                (sel && !upd_taken && ctr_reg[gi] != '0)      ? ctr_reg[gi] - 1'b1 :
                                                                ctr_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BHT_N; i++) begin
                ctr_reg[i] <= CTR_INIT;
            end
        end else begin
            for (int i = 0; i < BHT_N; i++) begin
                ctr_reg[i] <= ctr_next[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BTB_N; i++) begin
                btb_valid_reg[i]  <= 1'b0;
                btb_tag_reg[i]    <= '0;
                btb_target_reg[i] <= '0;
            end
        end else if (upd_en && upd_taken) begin
            btb_valid_reg[upd_btb_idx]  <= 1'b1;
            btb_tag_reg[upd_btb_idx]    <= upd_tag;
            btb_target_reg[upd_btb_idx] <= upd_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_branches_reg <= '0;
            stat_mispred_reg  <= '0;
        end else if (upd_en) begin
            stat_branches_reg <= stat_branches_reg + 32'd1;
            stat_mispred_reg  <= stat_mispred_reg + {31'd0, upd_mispredict};
        end
    end

    assign stat_branches = stat_branches_reg;
    assign stat_mispred  = stat_mispred_reg;

endmodule
